// File: rtl/serial_adder_seq_if.sv
// rtl/serial_adder_seq_if.sv - request/operand and bit-stream bundle for serial_adder_seq
interface serial_adder_seq_if #(
    parameter int WIDTH = 4
);
    logic             START;
    logic [WIDTH-1:0] A_IN;
    logic [WIDTH-1:0] B_IN;
    logic             CIN;
    logic             STEP;
    logic             A_BIT;
    logic             B_BIT;
    logic             TE_BIT;
    logic [3:0]       BIT_IDX;
    logic [WIDTH-1:0] SUM;
    logic             COUT;
    logic             BUSY;
    logic             DONE;

    modport master (
        output START, A_IN, B_IN, CIN, STEP,
        input  A_BIT, B_BIT, TE_BIT, BIT_IDX, SUM, COUT, BUSY, DONE
    );

    modport slave (
        input  START, A_IN, B_IN, CIN, STEP,
        output A_BIT, B_BIT, TE_BIT, BIT_IDX, SUM, COUT, BUSY, DONE
    );
endinterface

// File: rtl/serial_adder_seq.sv
// rtl/serial_adder_seq.sv - bit-serial add sequencer, LSB first; SERIAL_STEP_EN gates advance on STEP
module serial_adder_seq #(
    parameter int WIDTH = 4
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    serial_adder_seq_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_FIN   = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(WIDTH - 1);

    state_t           state;
    state_t           state_d;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [3:0]       idx;

    logic advance;
    logic in_shift;
    logic in_fin;
    logic load;
    logic step;
    logic s_bit;
    logic c_next;

`ifdef SERIAL_STEP_EN
    assign advance = bus.STEP;
`else
    logic unused_step;
    assign unused_step = bus.STEP;
    assign advance     = 1'b1;
`endif

    assign in_shift = (state == S_SHIFT);
    assign in_fin   = (state == S_FIN);
    // START is honoured in IDLE and FIN only; during SHIFT the operands are frozen
    assign load     = bus.START && !in_shift;
    assign step     = in_shift && advance;

    assign s_bit  = a_sh[0] ^ b_sh[0] ^ carry;
    assign c_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

    // state register
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // next-state selection
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (bus.START) state_d = S_SHIFT;
            S_SHIFT: if (advance && (idx == LAST_IDX)) state_d = S_FIN;
            S_FIN:   if (bus.START) state_d = S_SHIFT;
            default: state_d = S_IDLE;
        endcase
    end

    // operand shifters, running carry, sum accumulator and bit index
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            idx    <= 4'd0;
        end else if (load) begin
            a_sh   <= bus.A_IN;
            b_sh   <= bus.B_IN;
            sum_sh <= '0;
            carry  <= bus.CIN;
            idx    <= 4'd0;
        end else if (step) begin
            a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
            sum_sh <= {s_bit, sum_sh[WIDTH-1:1]};
            carry  <= c_next;
            if (idx != LAST_IDX) begin
                idx <= idx + 4'd1;
            end
        end
    end

    // outputs gated by state so idle/finished views read clean zeros
    always_comb begin
        bus.A_BIT   = in_shift & a_sh[0];
        bus.B_BIT   = in_shift & b_sh[0];
        bus.TE_BIT  = in_shift & carry;
        bus.BIT_IDX = in_shift ? idx : 4'd0;
        bus.SUM     = in_fin ? sum_sh : '0;
        bus.COUT    = in_fin & carry;
        bus.BUSY    = in_shift;
        bus.DONE    = in_fin;
    end
endmodule

// File: tb/tb_serial_adder_seq.sv
// tb/tb_serial_adder_seq.sv - directed checks for serial_adder_seq at WIDTH=4
module tb_serial_adder_seq;
    logic CLOCK_50 = 1'b0;
    logic RESET;
    int   passed = 0;
    int   total  = 0;

    serial_adder_seq_if #(.WIDTH(4)) bus ();

    serial_adder_seq #(.WIDTH(4)) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .bus      (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_abit"}, 32'(bus.A_BIT), 32'd0);
        check({tag, "_bbit"}, 32'(bus.B_BIT), 32'd0);
        check({tag, "_tebit"}, 32'(bus.TE_BIT), 32'd0);
        check({tag, "_idx"}, 32'(bus.BIT_IDX), 32'd0);
        check({tag, "_sum"}, 32'(bus.SUM), 32'd0);
        check({tag, "_cout"}, 32'(bus.COUT), 32'd0);
        check({tag, "_busy"}, 32'(bus.BUSY), 32'd0);
        check({tag, "_done"}, 32'(bus.DONE), 32'd0);
        check({tag, "_state"}, 32'(dut.state), 32'd0);
    endtask

    // te: hand-computed carry-in seen at each bit (bit i = step i); inj: step at which a stray START is pulsed (-1 none)
    task automatic do_add(input string tag, input logic [3:0] a, input logic [3:0] b, input logic cin,
                          input logic [3:0] te, input logic [3:0] exp_sum, input logic exp_cout, input int inj);
        bus.A_IN  = a;
        bus.B_IN  = b;
        bus.CIN   = cin;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_busy%0d", tag, i), 32'(bus.BUSY), 32'd1);
            check($sformatf("%s_done%0d", tag, i), 32'(bus.DONE), 32'd0);
            check($sformatf("%s_idx%0d", tag, i), 32'(bus.BIT_IDX), 32'(i));
            check($sformatf("%s_a%0d", tag, i), 32'(bus.A_BIT), 32'(a[i]));
            check($sformatf("%s_b%0d", tag, i), 32'(bus.B_BIT), 32'(b[i]));
            check($sformatf("%s_te%0d", tag, i), 32'(bus.TE_BIT), 32'(te[i]));
            check($sformatf("%s_sumgate%0d", tag, i), 32'(bus.SUM), 32'd0);
            if (i == inj) begin
                bus.A_IN  = 4'b1111;
                bus.B_IN  = 4'b1111;
                bus.CIN   = 1'b1;
                bus.START = 1'b1;
            end
            tick();
            bus.START = 1'b0;
        end
        check({tag, "_done"}, 32'(bus.DONE), 32'd1);
        check({tag, "_busy_off"}, 32'(bus.BUSY), 32'd0);
        check({tag, "_sum"}, 32'(bus.SUM), 32'(exp_sum));
        check({tag, "_cout"}, 32'(bus.COUT), 32'(exp_cout));
        check({tag, "_idx_fin"}, 32'(bus.BIT_IDX), 32'd0);
        check({tag, "_te_fin"}, 32'(bus.TE_BIT), 32'd0);
    endtask

    initial begin
        RESET     = 1'b1;
        bus.START = 1'b0;
        bus.A_IN  = 4'b0000;
        bus.B_IN  = 4'b0000;
        bus.CIN   = 1'b0;
        bus.STEP  = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        check_idle("rst");
        tick();
        check_idle("idle_hold");

        do_add("t1", 4'b0101, 4'b0011, 1'b0, 4'b1110, 4'b1000, 1'b0, -1);
        tick();
        tick();
        check("t1_hold_done", 32'(bus.DONE), 32'd1);
        check("t1_hold_sum", 32'(bus.SUM), 32'b1000);

        do_add("t2", 4'b1111, 4'b0001, 1'b0, 4'b1110, 4'b0000, 1'b1, -1);
        do_add("t3", 4'b0000, 4'b0000, 1'b1, 4'b0001, 4'b0001, 1'b0, -1);
        do_add("t3b", 4'b1111, 4'b1111, 1'b1, 4'b1111, 4'b1111, 1'b1, -1);
        do_add("t4", 4'b0101, 4'b0011, 1'b0, 4'b1110, 4'b1000, 1'b0, 2);
        tick();
        check("t4_no_restart", 32'(bus.DONE), 32'd1);

        bus.A_IN  = 4'b1111;
        bus.B_IN  = 4'b0001;
        bus.CIN   = 1'b1;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        tick();
        check("t5_idx1", 32'(bus.BIT_IDX), 32'd1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check_idle("t5_rst");
        do_add("t5", 4'b0110, 4'b0111, 1'b0, 4'b1100, 4'b1101, 1'b0, -1);

`ifdef SERIAL_STEP_EN
        bus.STEP  = 1'b0;
        bus.A_IN  = 4'b0101;
        bus.B_IN  = 4'b0011;
        bus.CIN   = 1'b0;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("st_idx", 32'(bus.BIT_IDX), 32'd0);
        check("st_abit", 32'(bus.A_BIT), 32'd1);
        check("st_done", 32'(bus.DONE), 32'd0);
        check("st_busy", 32'(bus.BUSY), 32'd1);
        for (int p = 0; p < 4; p++) begin
            bus.STEP = 1'b1;
            tick();
            bus.STEP = 1'b0;
            if (p < 3) begin
                check($sformatf("st_idx_p%0d", p), 32'(bus.BIT_IDX), 32'(p + 1));
                check($sformatf("st_done_p%0d", p), 32'(bus.DONE), 32'd0);
                tick();
                tick();
            end
        end
        check("st_done_end", 32'(bus.DONE), 32'd1);
        check("st_sum", 32'(bus.SUM), 32'b1000);
        check("st_cout", 32'(bus.COUT), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/serial_adder_seq.md
Name: serial_adder_seq

Overview:
- Bit-serial add sequencer sitting directly upstream of the 1-bit full-adder/HEX display stage.
- Latches two WIDTH-bit operands and walks them LSB-first, one bit per step.
- Per step, drives the current operand bits and running carry onto A_BIT/B_BIT/TE_BIT, which the display stage consumes on its A/B/TE inputs.
- Computes the same full-adder function internally, accumulating SUM and COUT so the complete multi-bit result is available when DONE.

Parameters:
- WIDTH, 4, operand/sum width in bits (legal range 2..16).

Ports:
- CLOCK_50  in  1  system clock, all logic on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  single-cycle request: load operands and begin.
- A_IN  in  WIDTH  operand A, sampled only on an accepted START.
- B_IN  in  WIDTH  operand B, sampled only on an accepted START.
- CIN  in  1  initial carry, sampled only on an accepted START.
- STEP  in  1  single-cycle advance pulse; used only when SERIAL_STEP_EN is defined, ignored otherwise.
- A_BIT  out  1  current A bit to the downstream adder.
- B_BIT  out  1  current B bit to the downstream adder.
- TE_BIT  out  1  current carry-in to the downstream adder.
- BIT_IDX  out  4  index of the bit being processed (0 = LSB).
- SUM  out  WIDTH  accumulated sum; valid while DONE=1.
- COUT  out  1  final carry-out; valid while DONE=1.
- BUSY  out  1  high in SHIFT.
- DONE  out  1  high in FIN.

Behaviour:
- Clocking and reset:
  - Single clock CLOCK_50; RESET is synchronous and active-high.
  - RESET=1 at an edge forces state IDLE and zeroes all registers. After reset, every output reads 0: A_BIT, B_BIT, TE_BIT, BIT_IDX, SUM, COUT, BUSY and DONE.
  - Reset mid-operation aborts the add with no residue. SUM/COUT are cleared.
- State register: IDLE, SHIFT, FIN.
- IDLE:
  - BUSY=0, DONE=0.
  - START=1 loads a_sh<=A_IN, b_sh<=B_IN, carry<=CIN, sum_sh<=0, idx<=0, then goes to SHIFT.
- SHIFT:
  - BUSY=1.
  - Combinational outputs: A_BIT=a_sh[0], B_BIT=b_sh[0], TE_BIT=carry, BIT_IDX=idx.
  - On an advance event:
    - s = a_sh[0]^b_sh[0]^carry
    - carry <= majority(a_sh[0], b_sh[0], carry)
    - sum_sh <= {s, sum_sh[WIDTH-1:1]}
    - a_sh and b_sh shift right with 0 fill
    - idx <= idx+1
  - The advance at idx==WIDTH-1 goes to FIN instead of incrementing idx.
  - Advance event = every clock by default (see Optional Feature).
  - START is ignored while in SHIFT, and operand inputs are not re-sampled.
- FIN:
  - DONE=1, SUM=sum_sh, COUT=carry.
  - A_BIT=B_BIT=TE_BIT=0, BIT_IDX=0.
  - Holds indefinitely. START=1 restarts exactly as from IDLE, in the same cycle: load, then SHIFT.
- Output gating: SUM and COUT read 0 outside FIN.
- Latency (free-running mode):
  - START sampled at edge t gives BUSY high in cycles t+1..t+WIDTH and DONE high from cycle t+WIDTH+1.
  - Back-to-back START in FIN gives DONE low for exactly WIDTH cycles.
- Arithmetic: modulo 2^WIDTH with carry out, so {COUT,SUM} = A_IN+B_IN+CIN (WIDTH+1 bits, unsigned). No overflow flag.
- Simultaneous events: RESET dominates START and STEP. In FIN, START dominates hold.

Optional Feature:
- Macro SERIAL_STEP_EN.
- When defined:
  - An advance event in SHIFT occurs only on a clock where STEP=1.
  - Each STEP pulse consumes one bit. STEP held high for k cycles advances k bits. The upstream debouncer/edge detector provides pulses.
  - A_BIT/B_BIT/TE_BIT remain stable between pulses so HEX0 can be read by eye.
  - STEP and START in the same SHIFT cycle: STEP acts, START is ignored.
  - STEP outside SHIFT has no effect.
- When undefined: STEP is unconnected internally and the sequencer advances every clock.

Test Plan (WIDTH=4):
- Reset, then check all outputs 0 and state IDLE. Then A_IN=0101, B_IN=0011, CIN=0, START 1 cycle -> BUSY 4 cycles; (A_BIT,B_BIT,TE_BIT) per cycle = (1,1,0),(0,1,1),(1,0,1),(0,0,1); DONE at t+5 with SUM=1000, COUT=0.
- A_IN=1111, B_IN=0001, CIN=0 -> SUM=0000, COUT=1; TE_BIT=1 from bit 1 onward.
- A_IN=0000, B_IN=0000, CIN=1 -> SUM=0001, COUT=0. Then START again in FIN with A_IN=1111, B_IN=1111, CIN=1 -> DONE drops for 4 cycles, then SUM=1111, COUT=1.
- START pulsed at BIT_IDX=2 during SHIFT with different operands -> ignored; original result delivered on schedule.
- RESET asserted at BIT_IDX=1 -> next cycle all outputs 0 and state IDLE; a subsequent add of 0110+0111 gives SUM=1101, COUT=0.
- With SERIAL_STEP_EN: START with 0101+0011, no STEP for 10 cycles -> BIT_IDX=0, A_BIT=1 held, DONE=0. Then 4 STEP pulses spaced 3 cycles apart -> DONE one cycle after the 4th pulse, SUM=1000.
